regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback requesters:
//  the ALU path (A) and the load/multicycle path (M).

---
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester register-file writeback arbiter with RAW scoreboard
// Registered single write port shared by ALU (A) and load/multicycle (M) paths.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter bit RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [AW-1:0]   m_rd,
  input  logic [XLEN-1:0] m_data,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [NREG-1:0] busy_vec,
  output logic            wb_we,
  output logic [AW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data
);

  logic            prio_m_q, prio_m_d;
  logic            wb_we_q, wb_we_d;
  logic [AW-1:0]   wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            grant_a, grant_m;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  // prio_m_q set means M wins the next contended cycle.
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (!rst) begin
      if (a_valid && m_valid) begin
        grant_m = RR_EN ? prio_m_q : 1'b1;
        grant_a = !grant_m;
      end else begin
        grant_a = a_valid;
        grant_m = m_valid;
      end
    end
  end

  assign a_ready  = grant_a;
  assign m_ready  = grant_m;
  assign win_rd   = grant_m ? m_rd : a_rd;
  assign win_data = grant_m ? m_data : a_data;

  always_comb begin
    prio_m_d  = prio_m_q;
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    busy_d    = busy_q;
    if (a_valid && m_valid && !rst) begin
      prio_m_d = grant_a;
    end
    if ((grant_a || grant_m) && (win_rd != '0)) begin
      wb_we_d   = 1'b1;
      wb_rd_d   = win_rd;
      wb_data_d = win_data;
    end
    // Clear first so a same-cycle allocation (younger producer) wins.
    if (wb_we_q) begin
      busy_d[wb_rd_q] = 1'b0;
    end
    if (alloc_valid && (alloc_rd != '0)) begin
      busy_d[alloc_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_m_q  <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
    end else begin
      prio_m_q  <= prio_m_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
    end
  end

  // The in-flight write lands before decode reads, so it never causes a stall.
  assign rs1_busy = busy_q[rs1] && !(wb_we_q && (wb_rd_q == rs1)) && (rs1 != '0);
  assign rs2_busy = busy_q[rs2] && !(wb_we_q && (wb_rd_q == rs2)) && (rs2 != '0);

  assign busy_vec = busy_q;
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized self-checking bench against a behavioural model
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, m_valid, alloc_valid;
  logic        a_ready, m_ready;
  logic [4:0]  a_rd, m_rd, alloc_rd, rs1, rs2;
  logic [31:0] a_data, m_data;
  logic        rs1_busy, rs2_busy;
  logic [31:0] busy_vec;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          mbusy[32];
  bit          exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  bit          last_contend_m;
  bit          ga, gm;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(32), .NREG(32), .AW(5), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_vec(busy_vec), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mbusy[i];
    return v;
  endfunction

  function automatic bit model_src_busy(input logic [4:0] rs);
    return mbusy[rs] && !(exp_we && exp_rd == rs) && rs != 0;
  endfunction

  // One clock: compare at negedge, advance model at posedge, return #1 after posedge.
  task automatic tick();
    bit          n_we;
    logic [4:0]  n_rd, w_rd;
    logic [31:0] n_data;
    bit          n_busy[32];
    @(negedge clk);
    ga = 0;
    gm = 0;
    if (!rst) begin
      if (a_valid && m_valid) begin
        if (last_contend_m) ga = 1; else gm = 1;
      end else begin
        ga = a_valid;
        gm = m_valid;
      end
    end
    check("a_ready", a_ready, ga);
    check("m_ready", m_ready, gm);
    check("wb_we", wb_we, exp_we);
    check("wb_rd", wb_rd, exp_rd);
    check("wb_data", wb_data, exp_data);
    check("busy_vec", busy_vec, model_vec());
    check("rs1_busy", rs1_busy, model_src_busy(rs1));
    check("rs2_busy", rs2_busy, model_src_busy(rs2));
    n_we   = 0;
    n_rd   = exp_rd;
    n_data = exp_data;
    n_busy = mbusy;
    if (ga || gm) begin
      w_rd = gm ? m_rd : a_rd;
      if (w_rd != 0) begin
        n_we   = 1;
        n_rd   = w_rd;
        n_data = gm ? m_data : a_data;
      end
    end
    if (exp_we) n_busy[exp_rd] = 0;
    if (alloc_valid && alloc_rd != 0) n_busy[alloc_rd] = 1;
    n_busy[0] = 0;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mbusy[i] = 0;
      exp_we = 0;
      exp_rd = 0;
      exp_data = 0;
      last_contend_m = 1;
    end else begin
      mbusy    = n_busy;
      exp_we   = n_we;
      exp_rd   = n_rd;
      exp_data = n_data;
      if (a_valid && m_valid) last_contend_m = gm;
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; a_valid = 0; m_valid = 0; alloc_valid = 0;
    a_rd = 0; m_rd = 0; alloc_rd = 0; a_data = 0; m_data = 0;
    rs1 = 0; rs2 = 0;
  endtask

  initial begin
    idle();
    exp_we = 0; exp_rd = 0; exp_data = 0; last_contend_m = 1;
    for (int i = 0; i < 32; i++) mbusy[i] = 0;

    // Reset held with both requesters active
    rst = 1; a_valid = 1; m_valid = 1; a_rd = 9; m_rd = 10;
    tick();
    tick();
    check("rst_wb_we", wb_we, 0);
    check("rst_busy", busy_vec, 0);
    idle();

    // Single A writeback
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
    tick();
    idle();
    check("t2_we", wb_we, 1);
    check("t2_rd", wb_rd, 5);
    check("t2_data", wb_data, 32'hDEADBEEF);
    tick();
    check("t2_we_off", wb_we, 0);

    // Contention: A,M,A,M
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; m_valid = 1; a_rd = 1; m_rd = 2;
      a_data = $urandom; m_data = $urandom;
      tick();
      check("t3_seq", wb_rd, (i % 2 == 0) ? 5'd1 : 5'd2);
    end
    idle();
    tick();

    // Scoreboard set, hazard, clear by M write
    alloc_valid = 1; alloc_rd = 7;
    tick();
    alloc_valid = 0; rs1 = 7;
    check("t4_busy_set", busy_vec[7], 1);
    tick();
    m_valid = 1; m_rd = 7; m_data = 32'h1234_5678;
    tick();
    m_valid = 0;
    check("t4_inflight_nostall", rs1_busy, 0);
    tick();
    check("t4_busy_clr", busy_vec[7], 0);

    // x0 drop, then set/clear collision on x3
    a_valid = 1; a_rd = 0; a_data = 32'hFFFF_FFFF;
    tick();
    a_valid = 0;
    check("t5_x0_we", wb_we, 0);
    a_valid = 1; a_rd = 3; a_data = 32'h3333;
    tick();
    a_valid = 0; alloc_valid = 1; alloc_rd = 3;
    tick();
    alloc_valid = 0;
    check("t5_set_wins", busy_vec[3], 1);

    // Reset mid-operation
    rst = 1;
    tick();
    rst = 0;
    for (int r = 4; r < 8; r++) begin
      alloc_valid = 1; alloc_rd = 5'(r);
      tick();
    end
    alloc_valid = 0;
    check("t6_pre", busy_vec, 32'h0000_00F0);
    rst = 1; m_valid = 1; m_rd = 6; m_data = 32'hABCD;
    tick();
    check("t6_busy", busy_vec, 0);
    check("t6_we", wb_we, 0);
    idle();

    // Random traffic honoring the hold-until-ready protocol
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!a_valid || ga) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_rd = 5'($urandom);
        a_data = $urandom;
      end
      if (!m_valid || gm) begin
        m_valid = ($urandom_range(0, 2) != 0);
        m_rd = 5'($urandom);
        m_data = $urandom;
      end
      alloc_valid = $urandom_range(0, 1);
      alloc_rd = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
